pcpi_nibble_sequencer: RTL

- Pin-level front end for a PCPI coprocessor, sitting between the 4-bit tile inputs and the coprocessor's PCPI port.
- Assembles a 32-bit instruction from 8 strobed nibbles and issues it over PCPI with valid held until ready.
- Captures the PCPI result and drains it back out as 8 acknowledged nibbles.
- Replaces the ad-hoc latch/state logic in the top level with one verified sequencer.

---
 rtl/pcpi_pkg.sv | 8 +
 rtl/pcpi_nibble_sequencer_if.sv | 25 ++
 rtl/pin_edge_sync.sv | 16 +
 rtl/pcpi_nibble_sequencer.sv | 77 +++++++
 4 files changed

// File: rtl/pcpi_pkg.sv
// pcpi_pkg: shared widths and FSM state encoding for the PCPI nibble sequencer.
package pcpi_pkg;
  localparam int PCPI_WORD_W = 32;
  localparam int NIB_W = 4;
  localparam int NIB_CNT = PCPI_WORD_W / NIB_W;
  localparam int IDX_W = $clog2(NIB_CNT);
  typedef enum logic [1:0] {LOAD, ISSUE, DRAIN, ERR} state_t;
endpackage

// File: rtl/pcpi_nibble_sequencer_if.sv
// pcpi_nibble_sequencer_if: pin-side nibble handshake plus PCPI request/response signals.
interface pcpi_nibble_sequencer_if;
  import pcpi_pkg::*;
  logic [NIB_W-1:0] nib_in;
  logic nib_stb;
  logic out_ack;
  logic [NIB_W-1:0] out_nib;
  logic out_valid;
  logic busy;
  logic error;
  logic pcpi_valid;
  logic [PCPI_WORD_W-1:0] pcpi_insn;
  logic pcpi_ready;
  logic pcpi_wr;
  logic [PCPI_WORD_W-1:0] pcpi_rd;
  logic pcpi_wait;
  modport master (
    input nib_in, nib_stb, out_ack, pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait,
    output out_nib, out_valid, busy, error, pcpi_valid, pcpi_insn
  );
  modport slave (
    output nib_in, nib_stb, out_ack, pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait,
    input out_nib, out_valid, busy, error, pcpi_valid, pcpi_insn
  );
endinterface

// File: rtl/pin_edge_sync.sv
// pin_edge_sync: 2-flop pin synchroniser plus rising-edge pulse, pulse suppressed while disabled.
module pin_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  input  logic i_en,
  output logic o_pulse
);
  logic [2:0] r_sync;
  // Forcing the edge flop high while disabled drops in-flight edges and stale high pins.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else r_sync <= {i_en ? r_sync[1] : 1'b1, r_sync[0], i_pin};
  end
  assign o_pulse = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/pcpi_nibble_sequencer.sv
// pcpi_nibble_sequencer: assembles nibbles into a PCPI instruction, issues it, drains the result as nibbles.
// Optional issue timeout with sticky error state when PCPI_TIMEOUT_EN is defined.
module pcpi_nibble_sequencer
  import pcpi_pkg::*;
#(
  parameter int NIBBLES = NIB_CNT
`ifdef PCPI_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input logic clk,
  input logic rst,
  pcpi_nibble_sequencer_if.master bus
);
  localparam int SW = $clog2(PCPI_WORD_W);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);
  state_t r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic [PCPI_WORD_W-1:0] r_insn, r_result;
  logic [SW-1:0] w_base;
  logic w_stb, w_ack, w_last, w_adv, w_timeout;
  pin_edge_sync u_stb (.clk(clk), .rst(rst), .i_pin(bus.nib_stb), .i_en(r_state == LOAD), .o_pulse(w_stb));
  pin_edge_sync u_ack (.clk(clk), .rst(rst), .i_pin(bus.out_ack), .i_en(r_state == DRAIN), .o_pulse(w_ack));
  assign w_last = r_idx == LAST;
  assign w_base = SW'(r_idx) << $clog2(NIB_W);
  assign w_adv = (r_state == LOAD && w_stb) || (r_state == DRAIN && w_ack);
`ifdef PCPI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  logic r_error;
  assign w_timeout = r_state == ISSUE && !bus.pcpi_ready && !bus.pcpi_wait && r_cnt == LIMIT;
  // Counter is zero outside ISSUE, so it starts clean on every ISSUE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_error <= 1'b0;
    end else begin
      r_cnt <= r_state != ISSUE ? '0 : bus.pcpi_wait ? r_cnt : r_cnt + CW'(1);
      if (w_timeout) r_error <= 1'b1;
    end
  end
  assign bus.error = r_error;
`else
  logic w_unused;
  assign w_unused = bus.pcpi_wait;
  assign w_timeout = 1'b0;
  assign bus.error = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LOAD:    w_next = (w_stb && w_last) ? ISSUE : LOAD;
      ISSUE:   w_next = bus.pcpi_ready ? DRAIN : w_timeout ? ERR : ISSUE;
      DRAIN:   w_next = (w_ack && w_last) ? LOAD : DRAIN;
      default: w_next = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_idx <= '0;
      r_insn <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_adv) r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      if (r_state == LOAD && w_stb) r_insn[w_base +: NIB_W] <= bus.nib_in;
      if (r_state == ISSUE && bus.pcpi_ready) r_result <= bus.pcpi_wr ? bus.pcpi_rd : '0;
    end
  end
  assign bus.pcpi_insn = r_insn;
  assign bus.pcpi_valid = r_state == ISSUE;
  assign bus.out_valid = r_state == DRAIN;
  assign bus.busy = r_state != LOAD;
  assign bus.out_nib = r_state == DRAIN ? r_result[w_base +: NIB_W] : '0;
endmodule
